move_sequencer: RTL and testbench
=================================

# move_sequencer

Turn-level move controller that owns the 8x8 board register, turns cursor `select` pulses into a source/destination pair, and drives the board validator. It sits directly upstream of the validator. It captures the move, holds `valid_input` until the validator returns a qualified verdict, and then either commits the move to the board and toggles the turn, or rejects it. `board_out` feeds the validator's `board_in` and the display.

## Interface
- `TIMEOUT`, 64: maximum cycles to wait for a validator verdict before forcing a reject.
- `MIN_LAT`, 2: number of initial VALIDATE cycles in which `valid_output` is ignored, to mask a stale verdict.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cursor_x`, `cursor_y`  in  3 each  currently highlighted square.
- `select`  in  1  one-cycle pulse: pick the square under the cursor.
- `cancel`  in  1  one-cycle pulse: drop the current source selection.
- `old_x`, `old_y`, `new_x`, `new_y`  out  3 each  captured move, sent to the validator.
- `piece_type`  out  4  code of the moving piece.
- `valid_input`  out  1  request to the validator; level, held through VALIDATE.
- `valid_move`, `valid_output`  in  1 each  validator verdict and verdict-ready flag.
- `board_out`  out  4 x [8][8]  board state, indexed `[x][y]`.
- `turn`  out  1  side to move: 0 = white, 1 = black.
- `src_selected`  out  1  high while a source square is held.
- `move_done`, `move_rejected`, `timeout`  out  1 each  one-cycle status pulses.

## Operation
- **Piece codes**
  - White 0–5: R, N, B, Q, K, P.
  - Black 6–11: same order.
  - 12 = empty; 13–15 are never written.
  - A square is owned by the side to move when `turn=0` and code ≤5, or `turn=1` and code is 6..11.
- **Reset board**
  - y=0: 0,1,2,3,4,2,1,0.
  - y=1: all 5.
  - y=2..5: all 12.
  - y=6: all 11.
  - y=7: 6,7,8,9,10,8,7,6.
  - White moves toward increasing y.
- **States:** WAIT_SRC, WAIT_DST, VALIDATE, COMMIT, REJECT. Reset state is WAIT_SRC.
- **WAIT_SRC**
  - `select` on an owned square: latch `old_x`/`old_y` and `piece_type`, then go to WAIT_DST.
  - `select` on an empty or opponent square: ignored.
  - `cancel`: ignored.
- **WAIT_DST**
  - `cancel`, or `select` on the source square itself: go to WAIT_SRC.
  - `select` on another owned square: go to REJECT without a validator request.
  - Any other `select`: latch `new_x`/`new_y`, clear the wait counter, go to VALIDATE.
- **VALIDATE**
  - `valid_input`=1 throughout; `select` and `cancel` are ignored.
  - The counter increments every cycle.
  - A verdict is qualified when `valid_output`=1 and counter ≥ MIN_LAT.
  - Qualified verdict with `valid_move`=1: go to COMMIT. With `valid_move`=0: go to REJECT.
  - Counter reaches TIMEOUT−1 with no qualified verdict: go to REJECT and pulse `timeout`.
  - Counter width is clog2(TIMEOUT)+1 bits and saturates (no wrap).
- **COMMIT** (one cycle)
  - Write `board[new]` = `piece_type` and `board[old]` = 12.
  - Promotion: code 5 landing on y=7 is written as 3; code 11 landing on y=0 is written as 9.
  - Toggle `turn`, pulse `move_done`, go to WAIT_SRC.
  - Only the board is written here.
- **REJECT** (one cycle)
  - Pulse `move_rejected`, go to WAIT_SRC.
  - Board and turn are unchanged.
- **Output state:** `src_selected` is high in WAIT_DST, VALIDATE, COMMIT and REJECT.
- **Deferred rules:** castling, en passant and check are outside this block's scope.

## Timing
- **Reset values**
  - Board: start position.
  - `turn`=0.
  - `old`/`new` coordinates and `piece_type`: all 0.
  - `valid_input`, `src_selected`, `move_done`, `move_rejected`, `timeout`: all 0.
- **Registered outputs:** all outputs come from registers; nothing is combinational from inputs.
- **Source select:** a `select` accepted at edge N gives `src_selected`=1 at N+1.
- **Destination select:**
  - A destination `select` sampled at edge N gives `valid_input`=1 from N+1.
  - `valid_input` drops on the edge that leaves VALIDATE.
- **Fastest move:** 2+MIN_LAT+1 edges from destination select to commit.
  - The verdict is sampled at VALIDATE cycle MIN_LAT.
  - At the next edge the state becomes COMMIT.
  - At the edge after that, `board_out` and `turn` update and `move_done`=1 for exactly one cycle.
- **Rejection:** `move_rejected` pulses for one cycle on exit from REJECT, concurrent with `src_selected`→0. `timeout` coincides with that `move_rejected`.
- **Simultaneous inputs:** `select` and `cancel` in the same cycle: `cancel` wins.
- **Reset mid-operation:** `reset` asserted in any state immediately restores the start board and WAIT_SRC. A pending validator verdict is discarded.

## Test plan
- **Reset:** assert `reset` → `board_out[0][0]`=0, `[4][0]`=4, `[3][1]`=5, `[4][4]`=12, `[4][7]`=10, `turn`=0, all pulses 0.
- **Legal commit (e2→e4):** `select` (4,1), then `select` (4,3); model answers `valid_output`=1, `valid_move`=1 at cycle 2 → `move_done` pulse, `[4][3]`=5, `[4][1]`=12, `turn`=1.
- **Ignored source:** with `turn`=0, `select` (0,6) → stays WAIT_SRC, `src_selected`=0. Then `select` (1,0), then `select` (3,0) (own queen) → `move_rejected` pulse, `valid_input` never rises.
- **Stale verdict and reject:** model holds `valid_output`=1, `valid_move`=1 from the previous move and flips `valid_move`=0 at VALIDATE cycle 2 → `move_rejected`, board unchanged.
- **Timeout:** model keeps `valid_output`=0 → after 64 VALIDATE cycles, `timeout` and `move_rejected` pulse together, `turn` unchanged.
- **Promotion and reset mid-operation:** white pawn at (2,6), validator accepts (2,6)→(2,7) → `[2][7]`=3. Separately, `reset` during VALIDATE → start board, `valid_input`=0.

Source files
------------

// File: rtl/move_sequencer.sv
// Turn-level move controller. It owns the 8x8 board, turns cursor selects into a
// source/destination pair, runs the validator handshake, then commits or rejects the move.
module move_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int MIN_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            cursor_x,
    input  logic [2:0]            cursor_y,
    input  logic                  select,
    input  logic                  cancel,
    output logic [2:0]            old_x,
    output logic [2:0]            old_y,
    output logic [2:0]            new_x,
    output logic [2:0]            new_y,
    output logic [3:0]            piece_type,
    output logic                  valid_input,
    input  logic                  valid_move,
    input  logic                  valid_output,
    output logic [7:0][7:0][3:0]  board_out,
    output logic                  turn,
    output logic                  src_selected,
    output logic                  move_done,
    output logic                  move_rejected,
    output logic                  timeout
);

    localparam int               CNT_W     = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] MIN_LAT_C = CNT_W'(MIN_LAT);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       EMPTY     = 4'd12;

    typedef enum logic [2:0] {
        WAIT_SRC,
        WAIT_DST,
        VALIDATE,
        COMMIT,
        REJECT
    } state_t;

    function automatic logic [3:0] back_rank(input logic [2:0] x);
        case (x)
            3'd0, 3'd7: return 4'd0;
            3'd1, 3'd6: return 4'd1;
            3'd2, 3'd5: return 4'd2;
            3'd3:       return 4'd3;
            default:    return 4'd4;
        endcase
    endfunction

    function automatic logic [7:0][7:0][3:0] start_board();
        logic [7:0][7:0][3:0] b;
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                b[x][y] = EMPTY;
            end
            b[x][0] = back_rank(3'(x));
            b[x][1] = 4'd5;
            b[x][6] = 4'd11;
            b[x][7] = back_rank(3'(x)) + 4'd6;
        end
        return b;
    endfunction

    function automatic logic owned(input logic [3:0] code, input logic side);
        return side ? (code >= 4'd6 && code <= 4'd11) : (code <= 4'd5);
    endfunction

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [7:0][7:0][3:0] board_q;
    logic                 turn_q;
    logic [2:0]           old_x_q, old_y_q, new_x_q, new_y_q;
    logic [3:0]           piece_q;
    logic                 valid_in_q;
    logic                 src_sel_q;
    logic                 done_q, rej_q, tmo_q;
    logic                 tmo_pend_q;

    logic [3:0]           cur_code;
    logic [CNT_W-1:0]     cnt_d;
    logic [3:0]           land_code_d;
    logic                 at_src;
    logic                 verdict;

    assign cur_code = board_q[cursor_x][cursor_y];
    assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign at_src   = (cursor_x == old_x_q) && (cursor_y == old_y_q);
    // Verdicts seen before MIN_LAT may belong to the previous request.
    assign verdict  = valid_output && (cnt_q >= MIN_LAT_C);

    always_comb begin
        land_code_d = piece_q;
        if (piece_q == 4'd5 && new_y_q == 3'd7) begin
            land_code_d = 4'd3;
        end else if (piece_q == 4'd11 && new_y_q == 3'd0) begin
            land_code_d = 4'd9;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= WAIT_SRC;
            cnt_q      <= '0;
            board_q    <= start_board();
            turn_q     <= 1'b0;
            old_x_q    <= 3'd0;
            old_y_q    <= 3'd0;
            new_x_q    <= 3'd0;
            new_y_q    <= 3'd0;
            piece_q    <= 4'd0;
            valid_in_q <= 1'b0;
            src_sel_q  <= 1'b0;
            done_q     <= 1'b0;
            rej_q      <= 1'b0;
            tmo_q      <= 1'b0;
            tmo_pend_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            rej_q  <= 1'b0;
            tmo_q  <= 1'b0;
            unique case (state_q)
                WAIT_SRC: begin
                    if (select && !cancel && owned(cur_code, turn_q)) begin
                        old_x_q   <= cursor_x;
                        old_y_q   <= cursor_y;
                        piece_q   <= cur_code;
                        src_sel_q <= 1'b1;
                        state_q   <= WAIT_DST;
                    end
                end
                WAIT_DST: begin
                    if (cancel || (select && at_src)) begin
                        src_sel_q <= 1'b0;
                        state_q   <= WAIT_SRC;
                    end else if (select && owned(cur_code, turn_q)) begin
                        tmo_pend_q <= 1'b0;
                        state_q    <= REJECT;
                    end else if (select) begin
                        new_x_q    <= cursor_x;
                        new_y_q    <= cursor_y;
                        cnt_q      <= '0;
                        valid_in_q <= 1'b1;
                        state_q    <= VALIDATE;
                    end
                end
                VALIDATE: begin
                    cnt_q <= cnt_d;
                    if (verdict) begin
                        valid_in_q <= 1'b0;
                        tmo_pend_q <= 1'b0;
                        state_q    <= valid_move ? COMMIT : REJECT;
                    end else if (cnt_q >= LAST_CNT) begin
                        valid_in_q <= 1'b0;
                        tmo_pend_q <= 1'b1;
                        state_q    <= REJECT;
                    end
                end
                COMMIT: begin
                    board_q[new_x_q][new_y_q] <= land_code_d;
                    board_q[old_x_q][old_y_q] <= EMPTY;
                    turn_q    <= ~turn_q;
                    done_q    <= 1'b1;
                    src_sel_q <= 1'b0;
                    state_q   <= WAIT_SRC;
                end
                REJECT: begin
                    rej_q      <= 1'b1;
                    tmo_q      <= tmo_pend_q;
                    tmo_pend_q <= 1'b0;
                    src_sel_q  <= 1'b0;
                    state_q    <= WAIT_SRC;
                end
                default: begin
                    state_q <= WAIT_SRC;
                end
            endcase
        end
    end

    assign old_x         = old_x_q;
    assign old_y         = old_y_q;
    assign new_x         = new_x_q;
    assign new_y         = new_y_q;
    assign piece_type    = piece_q;
    assign valid_input   = valid_in_q;
    assign board_out     = board_q;
    assign turn          = turn_q;
    assign src_selected  = src_sel_q;
    assign move_done     = done_q;
    assign move_rejected = rej_q;
    assign timeout       = tmo_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: a vector table for the select/validate flow,
// plus hand-written sequences for timeout, promotion and reset during validation.
module tb_move_sequencer;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [2:0]           cursor_x, cursor_y;
    logic                 select, cancel;
    logic [2:0]           old_x, old_y, new_x, new_y;
    logic [3:0]           piece_type;
    logic                 valid_input;
    logic                 valid_move, valid_output;
    logic [7:0][7:0][3:0] board_out;
    logic                 turn, src_selected, move_done, move_rejected, timeout;

    int checks = 0;
    int passes = 0;

    typedef struct {
        string      name;
        logic       sel, can;
        logic [2:0] x, y;
        logic       vo, vm;
        logic       src, vin, done, rej, tmo, trn;
        logic [2:0] px, py;
        logic [3:0] code;
    } vec_t;

    vec_t vecs[$];

    move_sequencer #(.TIMEOUT(64), .MIN_LAT(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .select       (select),
        .cancel       (cancel),
        .old_x        (old_x),
        .old_y        (old_y),
        .new_x        (new_x),
        .new_y        (new_y),
        .piece_type   (piece_type),
        .valid_input  (valid_input),
        .valid_move   (valid_move),
        .valid_output (valid_output),
        .board_out    (board_out),
        .turn         (turn),
        .src_selected (src_selected),
        .move_done    (move_done),
        .move_rejected(move_rejected),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input int s, c, x, y, vo, vm,
                                input int src, vin, done, rej, tmo, trn, px, py, code);
        vec_t v;
        v.name = n;
        v.sel  = (s != 0);
        v.can  = (c != 0);
        v.x    = 3'(x);
        v.y    = 3'(y);
        v.vo   = (vo != 0);
        v.vm   = (vm != 0);
        v.src  = (src != 0);
        v.vin  = (vin != 0);
        v.done = (done != 0);
        v.rej  = (rej != 0);
        v.tmo  = (tmo != 0);
        v.trn  = (trn != 0);
        v.px   = 3'(px);
        v.py   = 3'(py);
        v.code = 4'(code);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input logic s, c, input logic [2:0] x, y, input logic vo, vm);
        @(negedge clk);
        select       = s;
        cancel       = c;
        cursor_x     = x;
        cursor_y     = y;
        valid_output = vo;
        valid_move   = vm;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic doMove(input logic [2:0] sx, sy, dx, dy);
        applyStimulus(1'b1, 1'b0, sx, sy, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, dx, dy, 1'b0, 1'b0);
        idle();
        idle();
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1);
        idle();
        checkOutput("move.done", 8'(move_done), 8'd1);
    endtask

    initial begin
        logic ok;

        reset        = 1'b1;
        select       = 1'b0;
        cancel       = 1'b0;
        cursor_x     = 3'd0;
        cursor_y     = 3'd0;
        valid_output = 1'b0;
        valid_move   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        checkOutput("rst.b00", 8'(board_out[0][0]), 8'd0);
        checkOutput("rst.b40", 8'(board_out[4][0]), 8'd4);
        checkOutput("rst.b50", 8'(board_out[5][0]), 8'd2);
        checkOutput("rst.b31", 8'(board_out[3][1]), 8'd5);
        checkOutput("rst.b44", 8'(board_out[4][4]), 8'd12);
        checkOutput("rst.b47", 8'(board_out[4][7]), 8'd10);
        checkOutput("rst.b16", 8'(board_out[1][6]), 8'd11);
        checkOutput("rst.turn", 8'(turn), 8'd0);
        checkOutput("rst.src", 8'(src_selected), 8'd0);
        checkOutput("rst.vin", 8'(valid_input), 8'd0);
        checkOutput("rst.pulses", 8'({move_done, move_rejected, timeout}), 8'd0);
        checkOutput("rst.coords", 8'({old_x, old_y}), 8'd0);
        checkOutput("rst.piece", 8'(piece_type), 8'd0);

        //            name          s c x y vo vm  src vin dn rj to trn  px py code
        vecs.push_back(mk("ign_opp",     1,0,0,6,0,0, 0,0,0,0,0,0, 0,6,11));
        vecs.push_back(mk("ign_empty",   1,0,4,4,0,0, 0,0,0,0,0,0, 4,4,12));
        vecs.push_back(mk("ign_cancel",  0,1,0,0,0,0, 0,0,0,0,0,0, 0,0,0));
        vecs.push_back(mk("src_b1",      1,0,1,0,0,0, 1,0,0,0,0,0, 1,0,1));
        vecs.push_back(mk("dst_own",     1,0,3,0,0,0, 1,0,0,0,0,0, 3,0,3));
        vecs.push_back(mk("rej_own",     0,0,0,0,0,0, 0,0,0,1,0,0, 1,0,1));
        vecs.push_back(mk("rej_idle",    0,0,0,0,0,0, 0,0,0,0,0,0, 4,0,4));
        vecs.push_back(mk("src_g1",      1,0,6,0,0,0, 1,0,0,0,0,0, 6,0,1));
        vecs.push_back(mk("sel_cancel",  1,1,5,2,0,0, 0,0,0,0,0,0, 5,2,12));
        vecs.push_back(mk("src_g1b",     1,0,6,0,0,0, 1,0,0,0,0,0, 6,0,1));
        vecs.push_back(mk("reselect",    1,0,6,0,0,0, 0,0,0,0,0,0, 6,0,1));
        vecs.push_back(mk("src_e2",      1,0,4,1,0,0, 1,0,0,0,0,0, 4,1,5));
        vecs.push_back(mk("dst_e4",      1,0,4,3,0,0, 1,1,0,0,0,0, 4,3,12));
        vecs.push_back(mk("val_c0",      0,0,0,0,0,0, 1,1,0,0,0,0, 4,1,5));
        vecs.push_back(mk("val_c1",      0,0,0,0,0,0, 1,1,0,0,0,0, 4,1,5));
        vecs.push_back(mk("val_c2",      0,0,0,0,1,1, 1,0,0,0,0,0, 4,3,12));
        vecs.push_back(mk("commit",      0,0,0,0,0,0, 0,0,1,0,0,1, 4,3,5));
        vecs.push_back(mk("post_commit", 0,0,0,0,0,0, 0,0,0,0,0,1, 4,1,12));
        vecs.push_back(mk("ign_white",   1,0,4,3,0,0, 0,0,0,0,0,1, 4,3,5));
        vecs.push_back(mk("src_d7",      1,0,3,6,0,0, 1,0,0,0,0,1, 3,6,11));
        vecs.push_back(mk("dst_d5",      1,0,3,4,1,1, 1,1,0,0,0,1, 3,4,12));
        vecs.push_back(mk("stale_c0",    0,0,0,0,1,1, 1,1,0,0,0,1, 3,6,11));
        vecs.push_back(mk("stale_c1",    0,0,0,0,1,1, 1,1,0,0,0,1, 3,6,11));
        vecs.push_back(mk("verdict_no",  0,0,0,0,1,0, 1,0,0,0,0,1, 3,6,11));
        vecs.push_back(mk("rej_verdict", 0,0,0,0,1,1, 0,0,0,1,0,1, 3,4,12));
        vecs.push_back(mk("rej_idle2",   0,0,0,0,0,0, 0,0,0,0,0,1, 3,6,11));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].sel, vecs[i].can, vecs[i].x, vecs[i].y, vecs[i].vo, vecs[i].vm);
            checkOutput({vecs[i].name, ".src"},  8'(src_selected),  8'(vecs[i].src));
            checkOutput({vecs[i].name, ".vin"},  8'(valid_input),   8'(vecs[i].vin));
            checkOutput({vecs[i].name, ".done"}, 8'(move_done),     8'(vecs[i].done));
            checkOutput({vecs[i].name, ".rej"},  8'(move_rejected), 8'(vecs[i].rej));
            checkOutput({vecs[i].name, ".tmo"},  8'(timeout),       8'(vecs[i].tmo));
            checkOutput({vecs[i].name, ".turn"}, 8'(turn),          8'(vecs[i].trn));
            checkOutput({vecs[i].name, ".sq"},   8'(board_out[vecs[i].px][vecs[i].py]), 8'(vecs[i].code));
        end

        // Timeout: black a7 -> a6 with the validator silent for the whole window.
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd6, 1'b0, 1'b0);
        checkOutput("to.src", 8'(src_selected), 8'd1);
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd5, 1'b0, 1'b0);
        checkOutput("to.vin", 8'(valid_input), 8'd1);
        checkOutput("to.coords", 8'({old_x, old_y, new_x, new_y}), 8'({3'd6, 3'd0, 3'd5}));
        checkOutput("to.piece", 8'(piece_type), 8'd11);
        ok = 1'b1;
        for (int i = 0; i < 63; i++) begin
            idle();
            if (valid_input !== 1'b1 || move_rejected !== 1'b0 || timeout !== 1'b0) ok = 1'b0;
        end
        checkOutput("to.window", 8'(ok), 8'd1);
        idle();
        checkOutput("to.vin_drop", 8'(valid_input), 8'd0);
        checkOutput("to.early", 8'({move_rejected, timeout}), 8'd0);
        idle();
        checkOutput("to.rej", 8'(move_rejected), 8'd1);
        checkOutput("to.pulse", 8'(timeout), 8'd1);
        checkOutput("to.turn", 8'(turn), 8'd1);
        checkOutput("to.src_clr", 8'(src_selected), 8'd0);
        checkOutput("to.board", 8'(board_out[0][6]), 8'd11);
        idle();
        checkOutput("to.pulse_clr", 8'(timeout), 8'd0);

        // Promotion: clear c7, march the c-pawn to c7, then capture onto c8.
        doMove(3'd2, 3'd6, 3'd2, 3'd4);
        checkOutput("promo.turn0", 8'(turn), 8'd0);
        doMove(3'd2, 3'd1, 3'd2, 3'd6);
        checkOutput("promo.pawn", 8'(board_out[2][6]), 8'd5);
        doMove(3'd0, 3'd6, 3'd0, 3'd5);
        doMove(3'd2, 3'd6, 3'd2, 3'd7);
        checkOutput("promo.queen", 8'(board_out[2][7]), 8'd3);
        checkOutput("promo.src_empty", 8'(board_out[2][6]), 8'd12);
        checkOutput("promo.turn1", 8'(turn), 8'd1);

        // Reset mid-validation with an accepting verdict already on the bus.
        applyStimulus(1'b1, 1'b0, 3'd1, 3'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd2, 3'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1);
        checkOutput("mid.vin_before", 8'(valid_input), 8'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("mid.vin", 8'(valid_input), 8'd0);
        checkOutput("mid.src", 8'(src_selected), 8'd0);
        checkOutput("mid.turn", 8'(turn), 8'd0);
        checkOutput("mid.b27", 8'(board_out[2][7]), 8'd8);
        checkOutput("mid.b43", 8'(board_out[4][3]), 8'd12);
        @(negedge clk);
        reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1);
            if (move_done !== 1'b0 || src_selected !== 1'b0 || valid_input !== 1'b0) ok = 1'b0;
        end
        checkOutput("mid.discard", 8'(ok), 8'd1);
        checkOutput("mid.b17", 8'(board_out[1][7]), 8'd7);
        checkOutput("mid.b25", 8'(board_out[2][5]), 8'd12);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
